// File: rtl/dec_grant_arbiter_if.sv
// Request/grant bundle between the requesting units and dec_grant_arbiter.
// The master drives the requests, and the slave (the arbiter) drives the decoder-side outputs.
interface dec_grant_arbiter_if;
   logic [7:0] req;
   logic [2:0] sel;
   logic       sel_en;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;

   modport master (output req, input sel, input sel_en, input gnt, input busy, input timeout);
   modport slave  (input req, output sel, output sel_en, output gnt, output busy, output timeout);
endinterface

// File: rtl/dec_grant_arbiter.sv
// Round-robin arbiter driving a 3-to-8 enabled decoder, with break-before-make between grants.
// Optional hold-time watchdog is compiled in with ARB_TIMEOUT_EN (limit set by HOLD_MAX).
module dec_grant_arbiter #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   dec_grant_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
      $error("dec_grant_arbiter: HOLD_MAX must be 1..255");
   end

   function automatic logic [7:0] dec3to8(input logic [2:0] a);
      dec3to8 = 8'd1 << a;
   endfunction

   state_t     state_r, state_s;
   logic [2:0] sel_r, sel_s;
   logic       sel_en_r, sel_en_s;
   logic [7:0] gnt_r, gnt_s;
   logic [2:0] ptr_r, ptr_s;
   logic       busy_r, busy_s;
   logic       timeout_r, timeout_s;
   logic       found_s;
   logic [2:0] win_s;
`ifdef ARB_TIMEOUT_EN
   localparam logic [8:0] HOLD_LIM = 9'(HOLD_MAX);
   logic [7:0] hold_r, hold_s;
   logic       hold_hit_s;
`endif

   // Round-robin search: scan from farthest to nearest offset so the nearest set bit wins.
   always_comb begin
      found_s = 1'b0;
      win_s   = ptr_r;
      for (int k = 7; k >= 0; k--) begin
         if (bus.req[ptr_r + 3'(k)]) begin
            found_s = 1'b1;
            win_s   = ptr_r + 3'(k);
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Limit reached when this GRANT cycle would be number HOLD_MAX.
   always_comb begin
      hold_hit_s = (({1'b0, hold_r} + 9'd1) >= HOLD_LIM);
   end
`endif

   // Next-state and next-output logic for the IDLE/GRANT/RELEASE machine.
   always_comb begin
      state_s   = state_r;
      sel_s     = sel_r;
      sel_en_s  = sel_en_r;
      gnt_s     = gnt_r;
      ptr_s     = ptr_r;
      timeout_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_s    = hold_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_s  = ST_GRANT;
               sel_s    = win_s;
               sel_en_s = 1'b1;
               gnt_s    = dec3to8(win_s);
`ifdef ARB_TIMEOUT_EN
               hold_s   = 8'd0;
`endif
            end else begin
               sel_en_s = 1'b0;
               gnt_s    = 8'd0;
            end
         end
         ST_GRANT: begin
            if (!bus.req[sel_r]) begin
               state_s  = ST_RELEASE;
               sel_en_s = 1'b0;
               gnt_s    = 8'd0;
               ptr_s    = sel_r + 3'd1;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_hit_s) begin
               // Owner still requesting at the limit: forced release, flagged by timeout.
               state_s   = ST_RELEASE;
               sel_en_s  = 1'b0;
               gnt_s     = 8'd0;
               ptr_s     = sel_r + 3'd1;
               timeout_s = 1'b1;
            end else begin
               hold_s = hold_r + 8'd1;
`else
            end else begin
               state_s = ST_GRANT;
`endif
            end
         end
         ST_RELEASE: begin
            state_s  = ST_IDLE;
            sel_en_s = 1'b0;
            gnt_s    = 8'd0;
         end
         default: begin
            state_s  = ST_IDLE;
            sel_en_s = 1'b0;
            gnt_s    = 8'd0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and registered outputs; reset clears everything without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         sel_r     <= 3'd0;
         sel_en_r  <= 1'b0;
         gnt_r     <= 8'd0;
         ptr_r     <= 3'd0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_r    <= 8'd0;
`endif
      end else begin
         state_r   <= state_s;
         sel_r     <= sel_s;
         sel_en_r  <= sel_en_s;
         gnt_r     <= gnt_s;
         ptr_r     <= ptr_s;
         busy_r    <= busy_s;
         timeout_r <= timeout_s;
`ifdef ARB_TIMEOUT_EN
         hold_r    <= hold_s;
`endif
      end
   end

   assign bus.sel     = sel_r;
   assign bus.sel_en  = sel_en_r;
   assign bus.gnt     = gnt_r;
   assign bus.busy    = busy_r;
   assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_dec_grant_arbiter.sv
// Scoreboard bench for dec_grant_arbiter: directed plan scenarios plus random request traffic,
// checked against a cycle-level owner/turn model of the arbitration rules.
module tb_dec_grant_arbiter;

   localparam int HOLD = 4;

   typedef struct packed {
      logic [2:0] sel;
      logic       sel_en;
      logic [7:0] gnt;
      logic       busy;
      logic       timeout;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   int   glog[$];
   int   to_count = 0;

   // model: who owns the decoder, whose turn starts the next scan, dead cycles left
   int m_owner = -1;
   int m_last  = 0;
   int m_turn  = 0;
   int m_dead  = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   dec_grant_arbiter_if bus ();

   dec_grant_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      total++;
      if (act !== req_v) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req_v, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_turn = 0; m_dead = 0; m_held = 0; m_to = 1'b0;
   endtask

   task automatic model_release();
      m_turn  = (m_owner + 1) % 8;
      m_owner = -1;
      m_dead  = 1;
   endtask

   task automatic model_step(input logic [7:0] r);
      bit done;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) model_release();
`ifdef ARB_TIMEOUT_EN
         else if (m_held >= HOLD) begin
            m_to = 1'b1;
            model_release();
         end
`endif
         else m_held++;
      end else if (m_dead > 0) begin
         m_dead--;
      end else begin
         done = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (!done && r[(m_turn + k) % 8]) begin
               done    = 1'b1;
               m_owner = (m_turn + k) % 8;
               m_last  = m_owner;
               m_held  = 1;
            end
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.sel     = 3'(m_last);
      e.sel_en  = (m_owner >= 0);
      e.gnt     = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
      e.busy    = (m_owner >= 0) || (m_dead > 0);
      e.timeout = m_to;
      return e;
   endfunction

   // one clock cycle: called at a negedge, returns at the next negedge
   task automatic cyc(input logic [7:0] r);
      bus.req = r;
      @(posedge clk);
      if (rst_n) begin
         model_step(r);
         exp_q.push_back(model_out());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_sel", 32'(bus.sel), 32'd0);
      chk("rst_sel_en", 32'(bus.sel_en), 32'd0);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_timeout", 32'(bus.timeout), 32'd0);
      model_reset();
      bus.req = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      glog.delete();
      to_count = 0;
   endtask

   task automatic chk_log(input string nm, input int e[$]);
      chk({nm, "_len_ok"}, 32'(glog.size() >= e.size()), 32'd1);
      for (int i = 0; i < e.size(); i++) begin
         if (i < glog.size()) chk(nm, 32'(glog[i]), 32'(e[i]));
      end
   endtask

   // monitor: compare each sampled cycle against the oldest expectation
   initial begin
      exp_t e;
      logic prev_en;
      prev_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         chk("gnt_onehot", 32'($countones(bus.gnt) > 1), 32'd0);
         if (bus.sel_en && !prev_en) glog.push_back(int'(bus.sel));
         prev_en = bus.sel_en;
         if (bus.timeout) to_count++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sel", 32'(bus.sel), 32'(e.sel));
            chk("sel_en", 32'(bus.sel_en), 32'(e.sel_en));
            chk("gnt", 32'(bus.gnt), 32'(e.gnt));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("timeout", 32'(bus.timeout), 32'(e.timeout));
         end
      end
   end

   initial begin
      logic [7:0] r;
      int q[$];
      rst_n   = 1'b1;
      bus.req = 8'h00;
      @(negedge clk);
      do_reset();

      // idle stays idle, then a single request and its release
      repeat (3) cyc(8'h00);
      repeat (3) cyc(8'h08);
      repeat (4) cyc(8'h00);

      // reset mid-grant with owner 5
      do_reset();
      repeat (3) cyc(8'h20);
      do_reset();
      repeat (3) cyc(8'h00);

      // round-robin wrap: 2-cycle grants on 0x81
      do_reset();
      for (int i = 0; i < 20; i++) begin
         r = 8'h81;
         if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
         cyc(r);
      end
      q = '{0, 7, 0, 7};
      chk_log("rr_order", q);

      // all requesting, 1-cycle grants
      do_reset();
      for (int i = 0; i < 30; i++) begin
         r = 8'hFF;
         if (m_owner >= 0 && m_held == 1) r[m_owner] = 1'b0;
         cyc(r);
      end
      q = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      chk_log("ff_order", q);

      // non-owner request ignored during grant
      do_reset();
      repeat (2) cyc(8'h04);
      repeat (3) cyc(8'h14);
      repeat (4) cyc(8'h10);
      q = '{2, 4};
      chk_log("nonowner_order", q);

      // constant request from requester 1: watchdog behaviour
      do_reset();
      repeat (60) cyc(8'h02);
`ifdef ARB_TIMEOUT_EN
      chk("wd_timeouts_seen", 32'(to_count > 0), 32'd1);
      q = '{1, 1};
      chk_log("wd_regrant", q);
`else
      chk("wd_no_timeout", 32'(to_count), 32'd0);
      chk("wd_single_grant", 32'(glog.size()), 32'd1);
`endif
      repeat (3) cyc(8'h00);

      // random traffic with occasional mid-run resets
      do_reset();
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) == 0) r[$urandom_range(7, 0)] ^= 1'b1;
         if ($urandom_range(150, 0) == 0) begin
            do_reset();
         end else begin
            cyc(r);
         end
      end
      repeat (4) cyc(8'h00);

      @(posedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
